// File: rtl/pcie_dllp_pkg.sv
// -----------------------------------------------------------------------------
// pcie_dllp_pkg
// Shared definitions for the DLLP transmit path:
//   - DLLP type byte constants (Ack, Nak, InitFC1/InitFC2/UpdateFC for VC0)
//   - CRC-16 polynomial and seed used for DLLP protection
//   - transmit FSM state encoding
//   - crc16_step(): one bit of the serial CRC-16 update
// No ports (package).
// -----------------------------------------------------------------------------
package pcie_dllp_pkg;

  localparam logic [7:0] DLLP_ACK          = 8'h00;
  localparam logic [7:0] DLLP_NAK          = 8'h10;
  localparam logic [7:0] DLLP_INITFC1_P    = 8'h40;
  localparam logic [7:0] DLLP_INITFC1_NP   = 8'h50;
  localparam logic [7:0] DLLP_INITFC1_CPL  = 8'h60;
  localparam logic [7:0] DLLP_INITFC2_P    = 8'hC0;
  localparam logic [7:0] DLLP_INITFC2_NP   = 8'hD0;
  localparam logic [7:0] DLLP_INITFC2_CPL  = 8'hE0;
  localparam logic [7:0] DLLP_UPDATEFC_P   = 8'h80;
  localparam logic [7:0] DLLP_UPDATEFC_NP  = 8'h90;
  localparam logic [7:0] DLLP_UPDATEFC_CPL = 8'hA0;

  localparam logic [15:0] CRC_POLY = 16'h100B;
  localparam logic [15:0] CRC_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } dllp_state_e;

  // Shift one input bit into the CRC register (MSB-out, polynomial feedback).
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/pcie_dllp_tx_if.sv
// -----------------------------------------------------------------------------
// pcie_dllp_tx_if
// AXI-Stream style bus carrying DLLP beats from the data link layer to the PHY.
//   tdata/tkeep/tvalid/tlast/tuser : driven by the master (DLLP transmitter)
//   tready                         : driven by the slave (PHY)
// -----------------------------------------------------------------------------
interface pcie_dllp_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 4
);

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast,
                  output tuser, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast,
                  input tuser, output tready);

endinterface

// File: rtl/pcie_dllp_crc16.sv
// -----------------------------------------------------------------------------
// pcie_dllp_crc16
// Combinational DLLP CRC-16 over the four DLLP bytes.
//   data_i [31:0] : DLLP bytes, byte0 in [7:0]; each byte enters bit 0 first
//   crc_o  [15:0] : CRC field as sent, byte4 in [7:0], byte5 in [15:8]
// -----------------------------------------------------------------------------
module pcie_dllp_crc16
  import pcie_dllp_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_v;

  // Serial CRC unrolled over all 32 bits, then complemented and bit-reversed:
  // register bit 15 lands in byte4 bit 0 and register bit 0 in byte5 bit 7.
  always_comb begin
    crc_v = CRC_SEED;
    for (int i = 0; i < 32; i++) begin
      crc_v = crc16_step(crc_v, data_i[i]);
    end
    crc_o = 16'h0000;
    for (int j = 0; j < 16; j++) begin
      crc_o[j] = ~crc_v[15-j];
    end
  end

endmodule

// File: rtl/pcie_dllp_tx.sv
// -----------------------------------------------------------------------------
// pcie_dllp_tx
// Schedules and transmits Ack, Nak and flow-control DLLPs as two-beat frames.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   phy_link_up_i         : launches allowed only while high
//   ack_req_i, nak_req_i  : one-cycle requests, ackd_seq_i captured with each
//   fc_valid_i/fc_ready_o : FC request handshake, fields fc_type/hdr/data_i
//   m_axis_dllp2phy       : beat0 = DLLP bytes 0..3, beat1 = CRC-16 (tlast)
// -----------------------------------------------------------------------------
module pcie_dllp_tx
  import pcie_dllp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          phy_link_up_i,
  input  logic          ack_req_i,
  input  logic          nak_req_i,
  input  logic [11:0]   ackd_seq_i,
  input  logic          fc_valid_i,
  output logic          fc_ready_o,
  input  logic [7:0]    fc_type_i,
  input  logic [7:0]    fc_hdr_i,
  input  logic [11:0]   fc_data_i,
  pcie_dllp_tx_if.master m_axis_dllp2phy
);

  localparam logic [USER_WIDTH-1:0] TUSER_DLLP = USER_WIDTH'(1);

  dllp_state_e           state_q, state_d;
  logic                  ack_pend_q, ack_pend_d;
  logic                  nak_pend_q, nak_pend_d;
  logic [11:0]           seq_q, seq_d;
  logic [15:0]           crc_q, crc_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic [USER_WIDTH-1:0] tuser_q, tuser_d;

  logic                  launch_s, launch_nak_s, launch_ack_s, launch_fc_s;
  logic [31:0]           frame_s;
  logic [15:0]           crc_s;

  // Launch decision; Nak beats Ack beats FC.
  always_comb begin
    launch_s     = (state_q == ST_IDLE) && phy_link_up_i &&
                   (nak_pend_q || ack_pend_q || fc_valid_i);
    launch_nak_s = launch_s && nak_pend_q;
    launch_ack_s = launch_s && !nak_pend_q && ack_pend_q;
    launch_fc_s  = launch_s && !nak_pend_q && !ack_pend_q;
  end

  // DLLP bytes for whichever source would launch now (byte0 in [7:0]).
  always_comb begin
    if (nak_pend_q) begin
      frame_s = {seq_q[7:0], 4'h0, seq_q[11:8], 8'h00, DLLP_NAK};
    end else if (ack_pend_q) begin
      frame_s = {seq_q[7:0], 4'h0, seq_q[11:8], 8'h00, DLLP_ACK};
    end else begin
      frame_s = {fc_data_i[7:0], fc_hdr_i[1:0], 2'b00, fc_data_i[11:8],
                 2'b00, fc_hdr_i[7:2], fc_type_i};
    end
  end

  pcie_dllp_crc16 u_crc (
    .data_i (frame_s),
    .crc_o  (crc_s)
  );

  // Reset gating keeps the FC handshake quiet while the block is held in reset.
  assign fc_ready_o = launch_fc_s && !rst_i;

  // Pending flags: a request in the launch cycle of its own type re-arms the
  // flag after the clear, so it wins; link down drops everything pending.
  always_comb begin
    if (!phy_link_up_i) begin
      ack_pend_d = 1'b0;
      nak_pend_d = 1'b0;
    end else begin
      nak_pend_d = (nak_pend_q && !launch_nak_s) || nak_req_i;
      ack_pend_d = (ack_pend_q && !launch_nak_s && !launch_ack_s) || ack_req_i;
    end
    if (ack_req_i || nak_req_i) begin
      seq_d = ackd_seq_i;
    end else begin
      seq_d = seq_q;
    end
  end

  // Frame FSM and registered stream outputs.
  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tuser_d  = tuser_q;
    case (state_q)
      ST_IDLE: begin
        if (launch_s) begin
          state_d  = ST_BEAT0;
          crc_d    = crc_s;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          tdata_d  = DATA_WIDTH'(frame_s);
          tkeep_d  = KEEP_WIDTH'(4'hF);
          tuser_d  = TUSER_DLLP;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_BEAT0: begin
        if (m_axis_dllp2phy.tready) begin
          state_d  = ST_BEAT1;
          tdata_d  = DATA_WIDTH'({16'h0000, crc_q});
          tkeep_d  = KEEP_WIDTH'(4'h3);
          tlast_d  = 1'b1;
        end else begin
          state_d  = ST_BEAT0;
        end
      end
      ST_BEAT1: begin
        if (m_axis_dllp2phy.tready) begin
          state_d  = ST_IDLE;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          tdata_d  = '0;
          tkeep_d  = '0;
          tuser_d  = '0;
        end else begin
          state_d  = ST_BEAT1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tdata_d  = '0;
        tkeep_d  = '0;
        tuser_d  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ack_pend_q <= 1'b0;
      nak_pend_q <= 1'b0;
      seq_q      <= 12'h000;
      crc_q      <= 16'h0000;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tuser_q    <= '0;
    end else begin
      state_q    <= state_d;
      ack_pend_q <= ack_pend_d;
      nak_pend_q <= nak_pend_d;
      seq_q      <= seq_d;
      crc_q      <= crc_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tuser_q    <= tuser_d;
    end
  end

  assign m_axis_dllp2phy.tdata  = tdata_q;
  assign m_axis_dllp2phy.tkeep  = tkeep_q;
  assign m_axis_dllp2phy.tvalid = tvalid_q;
  assign m_axis_dllp2phy.tlast  = tlast_q;
  assign m_axis_dllp2phy.tuser  = tuser_q;

endmodule
